// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a variable-latency word-wide data memory.
// Checks alignment, drives a req/ack transaction, and returns extended load data.
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_ctl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        align_err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned BE_W    = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t              state_q;
  logic [2:0]          ctl_q;
  logic [1:0]          off_q;

  logic                req_illegal;
  logic [BE_W-1:0]     req_be;
  logic [DATA_W-1:0]   req_wdata_rep;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic [DATA_W-1:0]   load_ext;

  assign stall = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);

  // Request decode: legality, byte enables and lane-replicated store data.
  always_comb begin
    req_illegal   = 1'b0;
    req_be        = '0;
    req_wdata_rep = req_wdata;
    case (req_ctl)
      3'd0, 3'd1: begin
        req_be        = BE_W'(4'b0001 << req_addr[1:0]);
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      3'd2, 3'd3: begin
        req_illegal   = req_addr[0];
        req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      3'd4: begin
        req_illegal   = |req_addr[1:0];
        req_be        = 4'b1111;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Load lane selection and sign/zero extension from the latched size code.
  always_comb begin
    lane_byte = mem_rdata[{off_q, 3'b000} +: 8];
    lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ctl_q)
      3'd0:    load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_ext = {24'd0, lane_byte};
      3'd2:    load_ext = {{16{lane_half[15]}}, lane_half};
      3'd3:    load_ext = {16'd0, lane_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctl_q     <= '0;
      off_q     <= '0;
      done      <= 1'b0;
      align_err <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done      <= 1'b0;
      align_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ctl_q <= req_ctl;
            off_q <= req_addr[1:0];
            if (req_illegal) begin
              align_err <= 1'b1;
              state_q   <= ERR;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_be    <= req_be;
              mem_addr  <= WADDR_W'(req_addr[31:2]);
              mem_wdata <= req_wdata_rep;
              state_q   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) rdata <= load_ext;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized
// requests checked against an arithmetic reference model of sizes, lanes and extension.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_ctl;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, align_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [31:0] model_rdata;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_ctl(req_ctl),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .done(done),
    .align_err(align_err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: access size in bytes, 0 for an illegal size code.
  function automatic int size_of(input logic [2:0] ctl);
    case (ctl)
      3'd0, 3'd1: return 1;
      3'd2, 3'd3: return 2;
      3'd4:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [2:0] ctl, input logic [31:0] addr);
    int s;
    s = size_of(ctl);
    return (s != 0) && ((int'(addr[1:0]) % s) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] ctl, input logic [31:0] addr);
    logic [3:0] be;
    int s, off;
    s = size_of(ctl);
    off = int'(addr[1:0]);
    be = '0;
    for (int k = 0; k < 4; k++) if (k >= off && k < off + s) be[k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] ctl, input logic [31:0] wd);
    logic [31:0] r;
    int s;
    s = size_of(ctl);
    r = '0;
    for (int k = 0; k < 4; k++) r |= ((wd >> (8 * (k % s))) & 32'hFF) << (8 * k);
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] ctl, input logic [31:0] addr,
                                           input logic [31:0] word);
    longint unsigned v, mask;
    int s;
    s = size_of(ctl);
    v = longint'(word) >> (8 * int'(addr[1:0]));
    mask = (64'd1 << (8 * s)) - 64'd1;
    v &= mask;
    if ((ctl == 3'd0 || ctl == 3'd2) && (((v >> (8 * s - 1)) & 64'd1) != 0)) v |= ~mask;
    return v[31:0];
  endfunction

  task automatic scramble_req();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_ctl   = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Issues one request from an IDLE cycle and follows it to the next IDLE cycle.
  task automatic do_req(input logic we, input logic [2:0] ctl, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] word,
                        output int done_cyc);
    done_cyc  = -1;
    req_valid = 1'b1; req_we = we; req_ctl = ctl; req_addr = addr; req_wdata = wd;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL accept_stall: got %b exp 1", stall); end
    @(posedge clk); #1;
    scramble_req();
    mem_ack = 1'b0;
    if (!is_legal(ctl, addr)) begin
      #1;
      vectors++; if (align_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b exp 1", align_err); end
      vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL err_no_req: got %b exp 0", mem_req); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL err_no_done: got %b exp 0", done); end
      vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL err_stall: got %b exp 0", stall); end
      vectors++; if (rdata !== model_rdata) begin errors++; $display("FAIL err_rdata: got %h exp %h", rdata, model_rdata); end
      @(posedge clk); #1;
      vectors++; if (align_err !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL err_one_cycle: err %b req %b exp 0 0", align_err, mem_req);
      end
    end else begin
      for (int w = 0; w <= waits; w++) begin
        mem_ack   = (w == waits);
        mem_rdata = (w == waits) ? word : $urandom;
        #1;
        vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL acc_req: got %b exp 1", mem_req); end
        vectors++; if (mem_we !== we) begin errors++; $display("FAIL acc_we: got %b exp %b", mem_we, we); end
        vectors++; if (mem_be !== exp_be(ctl, addr)) begin
          errors++; $display("FAIL acc_be: got %b exp %b", mem_be, exp_be(ctl, addr));
        end
        vectors++; if (mem_addr !== addr[31:2]) begin
          errors++; $display("FAIL acc_addr: got %h exp %h", mem_addr, addr[31:2]);
        end
        if (we) begin
          vectors++; if (mem_wdata !== exp_wdata(ctl, wd)) begin
            errors++; $display("FAIL acc_wdata: got %h exp %h", mem_wdata, exp_wdata(ctl, wd));
          end
        end
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL acc_stall: got %b exp 1", stall); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL acc_done: got %b exp 0", done); end
        vectors++; if (rdata !== model_rdata) begin errors++; $display("FAIL acc_rdata: got %h exp %h", rdata, model_rdata); end
        @(posedge clk); #1;
        scramble_req();
      end
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (!we) model_rdata = exp_load(ctl, addr, word);
      #1;
      done_cyc = cyc;
      vectors++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b exp 1", done); end
      vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL done_req: got %b exp 0", mem_req); end
      vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL done_stall: got %b exp 0", stall); end
      vectors++; if (rdata !== model_rdata) begin errors++; $display("FAIL done_rdata: got %h exp %h", rdata, model_rdata); end
      @(posedge clk); #1;
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b exp 0", done); end
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      scramble_req();
      req_valid = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      vectors++; if (stall !== 1'b0 || done !== 1'b0 || align_err !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL idle: stall %b done %b err %b req %b exp 0 0 0 0", stall, done, align_err, mem_req);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    vectors++; if (done !== 1'b0 || align_err !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL %s_ctrl: done %b err %b req %b we %b exp 0 0 0 0", tag, done, align_err, mem_req, mem_we);
    end
    vectors++; if (mem_be !== 4'd0 || mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL %s_bus: be %h addr %h wdata %h exp 0 0 0", tag, mem_be, mem_addr, mem_wdata);
    end
    vectors++; if (rdata !== 32'd0) begin errors++; $display("FAIL %s_rdata: got %h exp 0", tag, rdata); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_ctl = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_low: got %b exp 0", stall); end
    req_valid = 1'b1; #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_valid: got %b exp 1", stall); end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = '0;
  endtask

  task automatic test_load_byte();
    int start, dc;
    start = cyc;
    do_req(1'b0, 3'd0, 32'h103, $urandom, 0, 32'h80FF_0000, dc);
    vectors++; if (dc - start !== 2) begin errors++; $display("FAIL lb_latency: got %0d exp 2", dc - start); end
    vectors++; if (rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h exp ffffff80", rdata); end
  endtask

  task automatic test_load_half_wait();
    int start, dc;
    start = cyc;
    do_req(1'b0, 3'd3, 32'h22, $urandom, 3, 32'h9ABC_1234, dc);
    vectors++; if (dc - start !== 5) begin errors++; $display("FAIL lhu_latency: got %0d exp 5", dc - start); end
    vectors++; if (rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_rdata: got %h exp 00009abc", rdata); end
  endtask

  task automatic test_store_byte();
    int dc;
    do_req(1'b1, 3'd0, 32'h41, 32'h1234_56A5, 2, $urandom, dc);
    vectors++; if (rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL sb_rdata_hold: got %h exp 00009abc", rdata); end
  endtask

  task automatic test_align_err();
    int dc;
    do_req(1'b1, 3'd4, 32'h06, $urandom, 0, $urandom, dc);
    do_req(1'b0, 3'd6, 32'h00, $urandom, 0, $urandom, dc);
    vectors++; if (rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL err_rdata_hold: got %h exp 00009abc", rdata); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [31:0] w1;
    w1 = $urandom;
    do_req(1'b0, 3'd4, 32'h10, $urandom, 0, w1, d1);
    vectors++; if (rdata !== w1) begin errors++; $display("FAIL b2b_word: got %h exp %h", rdata, w1); end
    do_req(1'b0, 3'd2, 32'h12, $urandom, 0, 32'h8001_0000, d2);
    vectors++; if (d2 - d1 !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d exp 3", d2 - d1); end
    vectors++; if (rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL b2b_half: got %h exp ffff8001", rdata); end
  endtask

  task automatic test_reset_in_access();
    req_valid = 1'b1; req_we = 1'b0; req_ctl = 3'd4; req_addr = 32'h20; req_wdata = $urandom;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rsta_req: got %b exp 1", mem_req); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("rsta");
    mem_ack = 1'b1; mem_rdata = $urandom;
    #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL rsta_stall: got %b exp 0", stall); end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    vectors++; if (done !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'd0) begin
      errors++; $display("FAIL rsta_late_ack: done %b req %b rdata %h exp 0 0 0", done, mem_req, rdata);
    end
    model_rdata = '0;
  endtask

  task automatic test_random();
    int dc;
    logic [2:0] ctl;
    logic [31:0] addr;
    for (int i = 0; i < 80; i++) begin
      ctl  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      addr = $urandom;
      do_req(1'($urandom_range(0, 1)), ctl, addr, $urandom, $urandom_range(0, 4), $urandom, dc);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_byte();
    test_load_half_wait();
    test_store_byte();
    test_align_err();
    test_back_to_back();
    idle_cycles(2);
    test_reset_in_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the MEM pipeline stage and a variable-latency, word-wide data memory. It takes one load/store request per instruction, checks alignment, and drives a request/acknowledge transaction with byte enables and lane-replicated store data. Load results are returned sign- or zero-extended according to the size code. The pipeline is stalled until the access completes.

## Interface
Parameters:
- none; address and data are fixed at 32 bits.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage has a load/store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_ctl  in  3  size code: 0 byte signed, 1 byte unsigned, 2 half signed, 3 half unsigned, 4 word, 5-7 illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  hold the pipeline (combinational).
- done  out  1  one-cycle completion pulse.
- align_err  out  1  one-cycle misaligned/illegal pulse.
- rdata  out  32  extended load result, registered.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  memory write.
- mem_be  out  4  byte enables; bit k = byte lane k (bits 8k+7:8k).
- mem_addr  out  30  word address (req_addr[31:2]).
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accepted write / returned read data this cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

## Operation
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE with req_valid: latch we, ctl, addr[1:0], and request fields.
  - Misaligned or illegal ctl -> ERR. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise -> ACCESS, with mem_* registered from the request.
- Byte enables and write data:
  - Byte: be = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111; wdata = wdata.
  - Loads drive the same be; memory ignores it.
- ACCESS: mem_req=1 and all mem_* held stable until mem_ack.
  - On ack: drop mem_req, go to DONE.
  - On a load ack: capture extended mem_rdata into rdata.
- Load extension:
  - Byte lane = addr[1:0].
  - Half = addr[1] ? [31:16] : [15:0].
  - ctl 0/2 sign-extend, 1/3 zero-extend, 4 passes the word through.
- DONE: done=1 for one cycle, then IDLE.
- ERR: align_err=1 for one cycle, no memory transaction, rdata unchanged, then IDLE.
- stall = (IDLE & req_valid) | ACCESS. It is low in DONE/ERR, so the pipeline advances exactly once per request and the next IDLE cycle sees the next instruction.
- Request inputs are ignored outside IDLE; changes during stall have no effect.
- mem_ack is ignored outside ACCESS.

## Timing
- Reset (sync):
  - State → IDLE.
  - stall follows its combinational definition; it is 1 in the reset-release cycle only if req_valid.
  - done, align_err, mem_req, mem_we = 0; mem_be = 0; mem_addr = 0; mem_wdata = 0; rdata = 0.
- Reset during ACCESS aborts the transaction; mem_req is 0 the cycle after the reset edge, and a later ack is ignored.
- Minimum latency with ack in the first ACCESS cycle:
  - Cycle 0: IDLE accepts, stall=1.
  - Cycle 1: ACCESS with mem_req=1 and ack, stall=1.
  - Cycle 2: DONE, done=1, rdata valid, stall=0.
  - Each extra wait cycle before ack adds one stall cycle.
- Error path: cycle 0 IDLE with stall=1; cycle 1 ERR with align_err=1 and stall=0.
- Back-to-back requests: a new request is accepted in the IDLE cycle right after DONE/ERR; there is no idle bubble beyond that.
- rdata holds its value until the next successful load completes.

## Test plan
- Load byte signed, addr=0x103, memory returns 0x80FF_0000 with ack in the first ACCESS cycle -> mem_addr=0x40, mem_be=1000, done at cycle 2, rdata=0xFFFF_FF80; stall high for cycles 0-1.
- Load half unsigned, addr=0x22, ack after 3 wait cycles, mem_rdata=0x9ABC_1234 -> rdata=0x0000_9ABC; stall high for 5 cycles, then done.
- Store byte, addr=0x41, wdata=0x1234_56A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, held until ack; done then IDLE; rdata unchanged.
- Store word, addr=0x06 -> align_err pulse in cycle 1, mem_req never asserted, stall drops in cycle 1. Also ctl=6 at addr 0 -> align_err, no access.
- Two back-to-back loads (word at 0x10, then half signed at 0x12 returning 0x0000_8001 in the upper half) -> two done pulses exactly 3 cycles apart with immediate acks; rdata=word, then 0xFFFF_8001.
- Assert rst while in ACCESS with no ack -> next cycle all outputs at reset values; an ack arriving one cycle later produces no done and no rdata change.
